sdio_host_data_phy: RTL

Host-side 4-bit SDIO data-line engine: the initiator counterpart to the device data PHY. It moves one block between a byte-stream interface and DAT[3:0], one nibble per `clk` (SDR, 4-bit mode only).
- Write: serialises start bit, data, per-line CRC16 and end bit, then receives the device CRC status token and waits out busy.
- Read: waits for the device start bit, deserialises data, checks per-line CRC16 and the end bit.

---
 rtl/sdio_host_data_phy_if.sv | 37 +++
 rtl/sdio_host_data_phy.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_host_data_phy_if.sv
// Block request, byte stream and DAT[3:0] pins of the host data PHY.
// slave = the PHY, master = the controller / bus model driving it.
interface sdio_host_data_phy_if;
  logic        i_activate;
  logic        i_write_flag;
  logic [12:0] i_data_count;
  logic        o_finished;
  logic        o_data_rd_stb;
  logic [7:0]  i_data_rd_data;
  logic        o_data_wr_stb;
  logic [7:0]  o_data_wr_data;
  logic        o_crc_err;
  logic        o_token_err;
  logic        o_timeout;
  logic [2:0]  o_status;
  logic        o_sdio_data_dir;
  logic [3:0]  o_sdio_data_out;
  logic [3:0]  i_sdio_data_in;

  modport slave (
    input  i_activate, i_write_flag, i_data_count,
    input  i_data_rd_data, i_sdio_data_in,
    output o_finished, o_data_rd_stb,
    output o_data_wr_stb, o_data_wr_data,
    output o_crc_err, o_token_err, o_timeout,
    output o_status, o_sdio_data_dir, o_sdio_data_out
  );

  modport master (
    output i_activate, i_write_flag, i_data_count,
    output i_data_rd_data, i_sdio_data_in,
    input  o_finished, o_data_rd_stb,
    input  o_data_wr_stb, o_data_wr_data,
    input  o_crc_err, o_token_err, o_timeout,
    input  o_status, o_sdio_data_dir, o_sdio_data_out
  );
endinterface

// File: rtl/sdio_host_data_phy.sv
// Host-side 4-bit SDIO data-line engine: one block per
// activation, one nibble per clk, per-line CRC16.
module sdio_host_data_phy #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  sdio_host_data_phy_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] W_START  = 4'd1;
  localparam logic [3:0] W_DATA   = 4'd2;
  localparam logic [3:0] W_CRC    = 4'd3;
  localparam logic [3:0] W_END    = 4'd4;
  localparam logic [3:0] W_TOKEN  = 4'd5;
  localparam logic [3:0] W_BUSY   = 4'd6;
  localparam logic [3:0] R_WAIT   = 4'd7;
  localparam logic [3:0] R_DATA   = 4'd8;
  localparam logic [3:0] R_CRC    = 4'd9;
  localparam logic [3:0] R_END    = 4'd10;
  localparam logic [3:0] FINISHED = 4'd11;

  typedef logic [3:0][15:0] crc4_t;

  function automatic crc4_t crc_upd(crc4_t c, logic [3:0] n);
    crc_upd = c;
    for (int i = 0; i < 4; i++)
      crc_upd[i] = {c[i][14:0], 1'b0}
                 ^ ({16{c[i][15] ^ n[i]}} & 16'h1021);
  endfunction

  logic [3:0]    state_q, state_d;
  logic [13:0]   cnt_q, cnt_d;
  logic [13:0]   tot_q, tot_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    tok_q, tok_d;
  logic [3:0]    hi_q, hi_d;
  crc4_t         crc_q, crc_d;
  crc4_t         rx_q, rx_d;
  logic          fin_q, fin_d;
  logic          rdstb_q, rdstb_d;
  logic          wrstb_q, wrstb_d;
  logic [7:0]    wrdat_q, wrdat_d;
  logic          crcerr_q, crcerr_d;
  logic          tokerr_q, tokerr_d;
  logic          tmoerr_q, tmoerr_d;
  logic [2:0]    sts_q, sts_d;
  logic          dir_q, dir_d;
  logic [3:0]    dout_q, dout_d;

  logic [3:0] din, wnib, crc_msb;
  logic [7:0] rd;
  logic       tmo_hit;
  crc4_t      crc_shl;

  assign din     = bus.i_sdio_data_in;
  assign rd      = bus.i_data_rd_data;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign wnib    = cnt_q[0] ? rd[3:0] : rd[7:4];

  always_comb begin
    crc_msb = '0;
    crc_shl = '0;
    for (int i = 0; i < 4; i++) begin
      crc_msb[i] = crc_q[i][15];
      crc_shl[i] = {crc_q[i][14:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tot_d    = tot_q;
    tmo_d    = tmo_q;
    tok_d    = tok_q;
    hi_d     = hi_q;
    crc_d    = crc_q;
    rx_d     = rx_q;
    rdstb_d  = 1'b0;
    wrstb_d  = 1'b0;
    wrdat_d  = wrdat_q;
    crcerr_d = crcerr_q;
    tokerr_d = tokerr_q;
    tmoerr_d = tmoerr_q;
    sts_d    = sts_q;
    dir_d    = dir_q;
    dout_d   = dout_q;
    // cancel beats every in-state decision, including timeout
    if (state_q != IDLE && !bus.i_activate) begin
      state_d = IDLE;
      dir_d   = 1'b0;
      dout_d  = 4'hF;
    end else begin
      unique case (state_q)
        IDLE: begin
          dir_d  = 1'b0;
          dout_d = 4'hF;
          crc_d  = '0;
          rx_d   = '0;
          if (bus.i_activate) begin
            crcerr_d = 1'b0;
            tokerr_d = 1'b0;
            tmoerr_d = 1'b0;
            sts_d    = 3'b000;
            tot_d    = {bus.i_data_count, 1'b0};
            if (bus.i_data_count == '0) begin
              state_d = FINISHED;
            end else if (bus.i_write_flag) begin
              state_d = W_START;
              dir_d   = 1'b1;
              dout_d  = 4'h0;
            end else begin
              state_d = R_WAIT;
              tmo_d   = '0;
            end
          end
        end
        W_START: begin
          state_d = W_DATA;
          dout_d  = rd[7:4];
          crc_d   = crc_upd(crc_q, rd[7:4]);
          cnt_d   = 14'd1;
        end
        W_DATA: begin
          if (cnt_q == tot_q) begin
            state_d = W_CRC;
            dout_d  = crc_msb;
            crc_d   = crc_shl;
            cnt_d   = 14'd1;
          end else begin
            dout_d  = wnib;
            crc_d   = crc_upd(crc_q, wnib);
            rdstb_d = cnt_q[0];
            cnt_d   = cnt_q + 14'd1;
          end
        end
        W_CRC: begin
          if (cnt_q == 14'd16) begin
            state_d = W_END;
            dout_d  = 4'hF;
          end else begin
            dout_d = crc_msb;
            crc_d  = crc_shl;
            cnt_d  = cnt_q + 14'd1;
          end
        end
        W_END: begin
          state_d = W_TOKEN;
          dir_d   = 1'b0;
          tok_d   = 3'd0;
          tmo_d   = '0;
        end
        W_TOKEN: begin
          if (tok_q == 3'd0) begin
            if (!din[0]) begin
              tok_d = 3'd1;
            end else if (tmo_hit) begin
              state_d  = FINISHED;
              tmoerr_d = 1'b1;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end else if (tok_q != 3'd4) begin
            sts_d = {sts_q[1:0], din[0]};
            tok_d = tok_q + 3'd1;
          end else begin
            tokerr_d = (sts_q != 3'b010) || !din[0];
            state_d  = W_BUSY;
            tmo_d    = '0;
          end
        end
        W_BUSY: begin
          if (din[0]) begin
            state_d = FINISHED;
          end else if (tmo_hit) begin
            state_d  = FINISHED;
            tmoerr_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        R_WAIT: begin
          if (din == 4'h0) begin
            state_d = R_DATA;
            cnt_d   = '0;
          end else if (tmo_hit) begin
            state_d  = FINISHED;
            tmoerr_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        R_DATA: begin
          crc_d = crc_upd(crc_q, din);
          if (!cnt_q[0]) begin
            hi_d = din;
          end else begin
            wrstb_d = 1'b1;
            wrdat_d = {hi_q, din};
          end
          if (cnt_q == tot_q - 14'd1) begin
            state_d = R_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end
        R_CRC: begin
          for (int i = 0; i < 4; i++)
            rx_d[i] = {rx_q[i][14:0], din[i]};
          if (cnt_q == 14'd15) state_d = R_END;
          else cnt_d = cnt_q + 14'd1;
        end
        R_END: begin
          crcerr_d = (rx_q != crc_q) || (din != 4'hF);
          state_d  = FINISHED;
        end
        FINISHED: begin
          dir_d  = 1'b0;
          dout_d = 4'hF;
        end
        default: state_d = IDLE;
      endcase
    end
    fin_d = (state_d == FINISHED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tot_q    <= '0;
      tmo_q    <= '0;
      tok_q    <= '0;
      hi_q     <= '0;
      crc_q    <= '0;
      rx_q     <= '0;
      fin_q    <= 1'b0;
      rdstb_q  <= 1'b0;
      wrstb_q  <= 1'b0;
      wrdat_q  <= '0;
      crcerr_q <= 1'b0;
      tokerr_q <= 1'b0;
      tmoerr_q <= 1'b0;
      sts_q    <= 3'b000;
      dir_q    <= 1'b0;
      dout_q   <= 4'hF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tot_q    <= tot_d;
      tmo_q    <= tmo_d;
      tok_q    <= tok_d;
      hi_q     <= hi_d;
      crc_q    <= crc_d;
      rx_q     <= rx_d;
      fin_q    <= fin_d;
      rdstb_q  <= rdstb_d;
      wrstb_q  <= wrstb_d;
      wrdat_q  <= wrdat_d;
      crcerr_q <= crcerr_d;
      tokerr_q <= tokerr_d;
      tmoerr_q <= tmoerr_d;
      sts_q    <= sts_d;
      dir_q    <= dir_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.o_finished      = fin_q;
  assign bus.o_data_rd_stb   = rdstb_q;
  assign bus.o_data_wr_stb   = wrstb_q;
  assign bus.o_data_wr_data  = wrdat_q;
  assign bus.o_crc_err       = crcerr_q;
  assign bus.o_token_err     = tokerr_q;
  assign bus.o_timeout       = tmoerr_q;
  assign bus.o_status        = sts_q;
  assign bus.o_sdio_data_dir = dir_q;
  assign bus.o_sdio_data_out = dout_q;
endmodule
